key_press_det: RTL

//  Upstream key front-end for the LED system: synchronises the raw active-low push-button,

---
 rtl/key_press_det_pkg.sv | 18 +
 rtl/key_sync.sv | 24 ++
 rtl/key_press_det.sv | 116 +++++++++++
 3 files changed

// File: rtl/key_press_det_pkg.sv
// Shared definitions for the key front-end: FSM state encodings and default timing constants.
// Imported by the key logic and by anything that needs to decode its state.
package key_press_det_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
  localparam logic [STATE_W-1:0] ST_DEB_PRESS   = 3'd1;
  localparam logic [STATE_W-1:0] ST_PRESSED     = 3'd2;
  localparam logic [STATE_W-1:0] ST_LONG_HELD   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DEB_RELEASE = 3'd4;

  // Defaults for a 50 MHz clock: 20 ms debounce, 1 s long press, 200 ms repeat
  localparam logic [31:0] DEB_MAX_DEF  = 32'd999_999;
  localparam logic [31:0] LONG_MAX_DEF = 32'd49_999_999;
  localparam logic [31:0] RPT_MAX_DEF  = 32'd9_999_999;

endpackage

// File: rtl/key_sync.sv
// Generic 2-FF synchroniser for asynchronous inputs; both stages reset to RST_VAL.
module key_sync #(
  parameter int unsigned        WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_press_det.sv
// Push-button front-end: synchronise, debounce and classify presses into short / long / repeat
// pulses, plus a debounced pressed level.
module key_press_det
  import key_press_det_pkg::*;
#(
  parameter logic [31:0] DEB_MAX  = DEB_MAX_DEF,
  parameter logic [31:0] LONG_MAX = LONG_MAX_DEF,
  parameter logic [31:0] RPT_MAX  = RPT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_ok,
  output logic key_long,
  output logic key_rpt,
  output logic key_down
);

  logic               key_s;
  logic [STATE_W-1:0] state;
  logic [31:0]        cnt;
  logic               long_flag;

  key_sync #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key),
    .q     (key_s)
  );

  // cnt is cleared on every state change, so each == compare is reached before any wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 32'd0;
      long_flag <= 1'b0;
      key_ok    <= 1'b0;
      key_long  <= 1'b0;
      key_rpt   <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_ok   <= 1'b0;
      key_long <= 1'b0;
      key_rpt  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!key_s) begin
            state <= ST_DEB_PRESS;
            cnt   <= 32'd0;
          end
        end
        ST_DEB_PRESS: begin
          if (key_s) begin
            state <= ST_IDLE;
            cnt   <= 32'd0;
          end else if (cnt == DEB_MAX) begin
            state    <= ST_PRESSED;
            cnt      <= 32'd0;
            key_down <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_PRESSED: begin
          if (key_s) begin
            state     <= ST_DEB_RELEASE;
            cnt       <= 32'd0;
            long_flag <= 1'b0;
          end else if (cnt == LONG_MAX) begin
            state    <= ST_LONG_HELD;
            cnt      <= 32'd0;
            key_long <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_LONG_HELD: begin
          if (key_s) begin
            state     <= ST_DEB_RELEASE;
            cnt       <= 32'd0;
            long_flag <= 1'b1;
          end else if (cnt == RPT_MAX) begin
            cnt     <= 32'd0;
            key_rpt <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_DEB_RELEASE: begin
          // A release bounce resumes the hold phase we came from with its timing restarted
          if (!key_s) begin
            state <= long_flag ? ST_LONG_HELD : ST_PRESSED;
            cnt   <= 32'd0;
          end else if (cnt == DEB_MAX) begin
            state    <= ST_IDLE;
            cnt      <= 32'd0;
            key_down <= 1'b0;
            key_ok   <= ~long_flag;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= 32'd0;
          long_flag <= 1'b0;
          key_down  <= 1'b0;
        end
      endcase
    end
  end

endmodule
